fifo_wr_packer: RTL
===================

FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

Interface
REQ-001 Parameter WIDTH, default 8, FIFO byte width.
REQ-002 Parameter BYTES, default 4, bytes per input word.
REQ-003 Parameter FRAME_WORDS, default 16, input words per frame; power of two, at least 2.
REQ-004 wclk  input  1  write-domain clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_data  input  WIDTH*BYTES  upstream word.
REQ-008 in_ready  output  1  packer accepts a word this cycle.
REQ-009 winc  output  1  FIFO write request.
REQ-010 wdata  output  WIDTH  FIFO write data.
REQ-011 wfull  input  1  FIFO full, wclk domain.
REQ-012 frame_done  output  1  one-cycle pulse at end of frame.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Word accept: in_valid & in_ready at a rising edge; byte write: winc & ~wfull at a rising edge.
REQ-015 States: IDLE, SEND, plus CKSUM when compiled per REQ-030.
REQ-016 IDLE: in_ready=1, winc=0; on accept, load in_data into the shift buffer, set byte_idx=0, go to SEND.
REQ-017 SEND: winc=1; wdata = buffer byte byte_idx, MSB byte first (byte_idx 0 = bits [WIDTH*BYTES-1 -: WIDTH]).
REQ-018 SEND with wfull=1: hold state, byte_idx, buffer and wdata unchanged; winc stays 1.
REQ-019 SEND byte write with byte_idx<BYTES-1: byte_idx increments by 1.
REQ-020 Last byte write (byte_idx=BYTES-1): word_cnt increments, modulo FRAME_WORDS.
REQ-021 in_ready is also 1 in SEND during a last-byte write unless that byte ends the frame; simultaneous accept reloads the buffer and stays in SEND with byte_idx=0 (zero bubble).
REQ-022 Last byte write, no accept, not frame end: go to IDLE.
REQ-023 Frame end = last-byte write with word_cnt=FRAME_WORDS-1; word_cnt wraps to 0, in_ready=0 that cycle.
REQ-024 Without REQ-030: at frame end, go to IDLE; frame_done=1 for the following cycle only.
REQ-025 winc and wdata are driven only from registered state; no combinational path from in_valid/in_data to winc/wdata.
REQ-026 Full-to-write throughput: one byte per cycle while wfull=0 and upstream keeps in_valid=1.

Reset
REQ-027 rst_n low: state=IDLE, byte_idx=0, word_cnt=0, buffer=0, checksum=0, winc=0, wdata=0, frame_done=0, busy=0.
REQ-028 in_ready=1 in the first cycle after rst_n release.
REQ-029 Reset mid-frame or mid-word discards buffered bytes and partial frame; no write after reset until a new accept.

Configuration
REQ-030 Macro FIFO_WR_CKSUM_EN defined: running XOR of all bytes written in the frame; at frame end go to CKSUM, where winc=1, wdata = checksum including the last byte, held under wfull; on its write, go to IDLE, clear checksum, frame_done=1 the following cycle; in_ready=0 in CKSUM.
REQ-031 Macro undefined: no checksum register, no CKSUM state; exactly BYTES*FRAME_WORDS writes per frame.

Verification
REQ-032 Reset: rst_n low 3 cycles with in_valid=1 -> winc=0, busy=0, frame_done=0; in_ready=1 after release.
REQ-033 Single word 0xA1B2C3D4, wfull=0 -> wdata 0xA1,0xB2,0xC3,0xD4 on 4 consecutive winc cycles, then IDLE.
REQ-034 Back-to-back words 0x01020304, 0x05060708, wfull=0 -> 8 consecutive writes, no bubble, in_ready high on cycle 4.
REQ-035 wfull=1 for 5 cycles while wdata=0xB2 -> 0xB2 held, winc=1, no byte skipped or duplicated.
REQ-036 16 words 0x00000001..0x00000010 -> frame_done one pulse after 64th byte; with FIFO_WR_CKSUM_EN, 65th byte = 0x10 (XOR of 0x01..0x10) then frame_done.
REQ-037 rst_n pulsed low after 2nd byte of a word -> no further writes; next word 0x11223344 starts with 0x11.

Source files
------------

// File: rtl/fifo_wr_packer.sv
// Purpose : unpacks BYTES-wide upstream words into a byte-wide FIFO write port, MSB byte first,
//           and marks frame boundaries every FRAME_WORDS words (optional trailing XOR checksum
//           byte when FIFO_WR_CKSUM_EN is defined).
// Latency : first byte of an accepted word is presented the cycle after the accept; one byte per
//           cycle while wfull is low, with zero bubble between words of a frame.
// Backpressure: wfull holds state, buffer and wdata with winc kept high; in_ready only opens in IDLE
//           or on the last-byte write of a word that does not end the frame.
module fifo_wr_packer #(
  parameter int WIDTH       = 8,
  parameter int BYTES       = 4,
  parameter int FRAME_WORDS = 16
) (
  input  logic                     wclk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH*BYTES-1:0]   in_data,
  output logic                     in_ready,
  output logic                     winc,
  output logic [WIDTH-1:0]         wdata,
  input  logic                     wfull,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int DW   = WIDTH * BYTES;
  localparam int IDXW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNTW = $clog2(FRAME_WORDS);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(BYTES - 1);
  localparam logic [CNTW-1:0] LAST_WORD = CNTW'(FRAME_WORDS - 1);

`ifdef FIFO_WR_CKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CKSUM = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t          state_q, state_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic [IDXW-1:0] byte_idx_q, byte_idx_d;
  logic [CNTW-1:0] word_cnt_q, word_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic            last_byte;
  logic            frame_end;
`ifdef FIFO_WR_CKSUM_EN
  logic [WIDTH-1:0] cksum_q, cksum_d;
`endif

  // The buffer is shifted left on every byte write, so the current byte is always the top slice.
  assign last_byte  = (byte_idx_q == LAST_IDX);
  assign frame_end  = last_byte && (word_cnt_q == LAST_WORD);
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  // State, buffer and counters; everything clears on reset so a partial word/frame is dropped.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      byte_idx_q   <= '0;
      word_cnt_q   <= '0;
      frame_done_q <= 1'b0;
`ifdef FIFO_WR_CKSUM_EN
      cksum_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      byte_idx_q   <= byte_idx_d;
      word_cnt_q   <= word_cnt_d;
      frame_done_q <= frame_done_d;
`ifdef FIFO_WR_CKSUM_EN
      cksum_q      <= cksum_d;
`endif
    end
  end

  // Next-state and outputs; winc/wdata depend only on registered state, never on in_valid/in_data.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    byte_idx_d   = byte_idx_q;
    word_cnt_d   = word_cnt_q;
    frame_done_d = 1'b0;
`ifdef FIFO_WR_CKSUM_EN
    cksum_d      = cksum_q;
`endif
    in_ready     = 1'b0;
    winc         = 1'b0;
    wdata        = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_d      = in_data;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end

      SEND: begin
        winc     = 1'b1;
        wdata    = buf_q[DW-1 -: WIDTH];
        // Reopen upstream only when this cycle's write empties the buffer and the frame continues.
        in_ready = ~wfull & last_byte & ~frame_end;
        if (!wfull) begin
`ifdef FIFO_WR_CKSUM_EN
          cksum_d = cksum_q ^ buf_q[DW-1 -: WIDTH];
`endif
          if (!last_byte) begin
            byte_idx_d = byte_idx_q + 1'b1;
            buf_d      = buf_q << WIDTH;
          end else begin
            word_cnt_d = frame_end ? '0 : (word_cnt_q + 1'b1);
            if (frame_end) begin
`ifdef FIFO_WR_CKSUM_EN
              state_d      = CKSUM;
`else
              state_d      = IDLE;
              frame_done_d = 1'b1;
`endif
            end else if (in_valid) begin
              buf_d      = in_data;
              byte_idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

`ifdef FIFO_WR_CKSUM_EN
      CKSUM: begin
        winc  = 1'b1;
        wdata = cksum_q;
        if (!wfull) begin
          state_d      = IDLE;
          cksum_d      = '0;
          frame_done_d = 1'b1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

endmodule
